// File: rtl/sort_pru_rd.sv
// rtl/sort_pru_rd.sv - counting-sort read side: scans a count bank and emits each address count times (SORT_PRU_CLR_EN enables clear-on-read)
module sort_pru_rd #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl2pru_start_vld_i,
    input  logic                  ctrl_rd_sel_i,
    output logic                  pru2ctrl_rd_done_vld_o,
    output logic                  pru_busy_o,
    output logic                  pru2mem_rd_en_o,
    output logic                  pru2mem_rd_bank_o,
    output logic [DATA_WIDTH-1:0] pru2mem_rd_addr_o,
    input  logic [CNT_WIDTH-1:0]  mem2pru_rd_data_i,
    output logic                  pru2mem_clr_en_o,
    output logic                  pru2mem_clr_bank_o,
    output logic [DATA_WIDTH-1:0] pru2mem_clr_addr_o,
    output logic                  pru_out_vld_o,
    output logic [DATA_WIDTH-1:0] pru_out_data_o,
    input  logic                  pru_out_rdy_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        EMIT,
        DONE
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ADDR_TOP = '1;
    localparam logic [DATA_WIDTH-1:0] ADDR_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] addr, addr_nxt;
    logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
    logic                  bank, bank_nxt;
    logic                  accept;
    logic                  at_top;

    assign accept = (state == EMIT) && pru_out_rdy_i;
    assign at_top = (addr == ADDR_TOP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            addr  <= '0;
            cnt   <= '0;
            bank  <= 1'b0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            cnt   <= cnt_nxt;
            bank  <= bank_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        cnt_nxt   = cnt;
        bank_nxt  = bank;
        case (state)
            IDLE: begin
                if (ctrl2pru_start_vld_i) begin
                    bank_nxt  = ctrl_rd_sel_i;
                    addr_nxt  = '0;
                    state_nxt = RD;
                end
            end
            RD: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_nxt = mem2pru_rd_data_i;
                if (mem2pru_rd_data_i != '0) begin
                    state_nxt = EMIT;
                end else if (at_top) begin
                    state_nxt = DONE;
                end else begin
                    addr_nxt  = addr + ADDR_ONE;
                    state_nxt = RD;
                end
            end
            EMIT: begin
                if (accept) begin
                    cnt_nxt = cnt - CNT_ONE;
                    // The last beat of a run moves straight on, so vld drops the next cycle.
                    if (cnt == CNT_ONE) begin
                        if (at_top) begin
                            state_nxt = DONE;
                        end else begin
                            addr_nxt  = addr + ADDR_ONE;
                            state_nxt = RD;
                        end
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state register so reset clears them at once.
    assign pru_busy_o             = (state != IDLE);
    assign pru2ctrl_rd_done_vld_o = (state == DONE);
    assign pru2mem_rd_en_o        = (state == RD);
    assign pru2mem_rd_bank_o      = (state == RD) && bank;
    assign pru2mem_rd_addr_o      = (state == RD) ? addr : '0;
    assign pru_out_vld_o          = (state == EMIT);
    assign pru_out_data_o         = (state == EMIT) ? addr : '0;

`ifdef SORT_PRU_CLR_EN
    assign pru2mem_clr_en_o   = (state == WAIT);
    assign pru2mem_clr_bank_o = (state == WAIT) && bank;
    assign pru2mem_clr_addr_o = (state == WAIT) ? addr : '0;
`else
    assign pru2mem_clr_en_o   = 1'b0;
    assign pru2mem_clr_bank_o = 1'b0;
    assign pru2mem_clr_addr_o = '0;
`endif

endmodule

// File: tb/tb_sort_pru_rd.sv
// tb/tb_sort_pru_rd.sv - self-checking bench for sort_pru_rd against a queue-based reference model
module tb_sort_pru_rd;

    localparam int DW = 2;
    localparam int CW = 16;
    localparam int NA = 1 << DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          sel = 1'b0;
    logic          done;
    logic          busy;
    logic          rd_en;
    logic          rd_bank;
    logic [DW-1:0] rd_addr;
    logic [CW-1:0] rd_data = '0;
    logic          clr_en;
    logic          clr_bank;
    logic [DW-1:0] clr_addr;
    logic          vld;
    logic [DW-1:0] data;
    logic          rdy = 1'b1;

    logic [CW-1:0] mem  [0:1][0:NA-1];
    logic [CW-1:0] init [0:1][0:NA-1];
    logic          load = 1'b0;

    int checks = 0;
    int errors = 0;

    sort_pru_rd #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .ctrl2pru_start_vld_i   (start),
        .ctrl_rd_sel_i          (sel),
        .pru2ctrl_rd_done_vld_o (done),
        .pru_busy_o             (busy),
        .pru2mem_rd_en_o        (rd_en),
        .pru2mem_rd_bank_o      (rd_bank),
        .pru2mem_rd_addr_o      (rd_addr),
        .mem2pru_rd_data_i      (rd_data),
        .pru2mem_clr_en_o       (clr_en),
        .pru2mem_clr_bank_o     (clr_bank),
        .pru2mem_clr_addr_o     (clr_addr),
        .pru_out_vld_o          (vld),
        .pru_out_data_o         (data),
        .pru_out_rdy_i          (rdy)
    );

    always #5 clk = ~clk;

    // Count memory: one-cycle read latency, write-zero port, bulk preload.
    always @(posedge clk) begin
        if (load) begin
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < NA; a++)
                    mem[b][a] <= init[b][a];
        end else begin
            if (rd_en) rd_data <= mem[rd_bank][rd_addr];
            if (clr_en) mem[clr_bank][clr_addr] <= '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_load();
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
    endtask

    // mode 0: rdy always 1, mode 1: rdy pattern 1,0,0,1, mode 2: random rdy
    task automatic run_scan(input logic s, input int mode, input bit mid_start);
        int exp_q[$];
        int got_q[$];
        int exp_done, exp_first, c, done_c, ndone, first_vld;
        bit pv, pacc, seen_nz;
        logic [DW-1:0] pd;
        int pat [4] = '{1, 0, 0, 1};

        exp_done  = 1;
        exp_first = 1;
        seen_nz   = 0;
        for (int a = 0; a < NA; a++) begin
            for (int k = 0; k < int'(init[s][a]); k++) exp_q.push_back(a);
            exp_done += 2 + int'(init[s][a]);
            if (!seen_nz) exp_first += 2;
            if (init[s][a] != 0) seen_nz = 1;
        end

        @(posedge clk); #1;
        start = 1'b1;
        sel   = s;
        @(posedge clk); #1;
        start = 1'b0;
        sel   = ~s;
        c = 1; done_c = -1; ndone = 0; first_vld = -1; pv = 0; pacc = 0; pd = '0;
        chk("rd_en_latency", {31'd0, rd_en}, 1);
        while (c < 500) begin
            case (mode)
                0: rdy = 1'b1;
                1: rdy = pat[c % 4][0];
                default: rdy = $urandom_range(0, 1) == 1;
            endcase
            if (mid_start) start = (c == 4);
            if (rd_en) chk("rd_bank", {31'd0, rd_bank}, {31'd0, s});
            if (vld) begin
                if (first_vld < 0) first_vld = c;
                if (pv && !pacc) chk("stable_data", {30'd0, data}, {30'd0, pd});
                if (rdy) got_q.push_back(int'(data));
            end
            if (done) begin
                ndone++;
                if (done_c < 0) done_c = c;
            end
            pv = vld; pacc = vld & rdy; pd = data;
            if (done_c >= 0 && c >= done_c + 4) break;
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        rdy   = 1'b1;

        chk("done_count", ndone, 1);
        chk("beat_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("beat_value", got_q[i], exp_q[i]);
        if (exp_q.size() == 0) chk("no_vld", first_vld, -1);
        else chk("first_vld", first_vld, exp_first);
        if (mode == 0) chk("done_cycle", done_c, exp_done);
        chk("idle_busy", {31'd0, busy}, 0);
        for (int a = 0; a < NA; a++) begin
`ifdef SORT_PRU_CLR_EN
            chk("bank_cleared", mem[s][a], 0);
`else
            chk("bank_kept", mem[s][a], init[s][a]);
`endif
            chk("other_bank", mem[~s][a], init[~s][a]);
        end
    endtask

    task automatic set_bank(input int b, input int c0, input int c1, input int c2, input int c3);
        init[b][0] = CW'(c0); init[b][1] = CW'(c1);
        init[b][2] = CW'(c2); init[b][3] = CW'(c3);
    endtask

    initial begin
        int nd, wc;
        set_bank(0, 0, 0, 0, 0);
        set_bank(1, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {20'd0, done, busy, rd_en, rd_bank, rd_addr, clr_en, clr_bank, clr_addr, vld}, 0);
        chk("reset_data", {30'd0, data}, 0);
        @(negedge clk) rst = 1'b1;

        // Emit order, full-rate
        set_bank(0, 2, 0, 1, 0); set_bank(1, 7, 7, 7, 7);
        do_load();
        run_scan(1'b0, 0, 1'b0);

        // Backpressure
        do_load();
        run_scan(1'b0, 1, 1'b0);

        // Bank select
        set_bank(0, 5, 5, 5, 5); set_bank(1, 0, 0, 0, 3);
        do_load();
        run_scan(1'b1, 0, 1'b0);

        // Empty bank
        set_bank(0, 0, 0, 0, 0); set_bank(1, 0, 0, 0, 0);
        do_load();
        run_scan(1'b0, 0, 1'b0);

        // Start while busy, then a fresh start after done
        set_bank(0, 2, 0, 1, 0); set_bank(1, 1, 1, 1, 1);
        do_load();
        run_scan(1'b0, 0, 1'b1);
        run_scan(1'b1, 0, 1'b0);

        // Reset mid-EMIT
        set_bank(0, 3, 0, 0, 0);
        do_load();
        @(posedge clk); #1 start = 1'b1; sel = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        wc = 0;
        while (!vld && wc < 20) begin
            @(posedge clk); #1;
            wc++;
        end
        chk("reach_emit", {31'd0, vld}, 1);
        rst = 1'b0;
        #1;
        chk("rst_vld", {31'd0, vld}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        @(negedge clk) rst = 1'b1;
        nd = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        chk("no_done_after_reset", nd, 0);
        chk("idle_after_reset", {31'd0, busy}, 0);

        // Randomized tasks against the reference model
        for (int it = 0; it < 8; it++) begin
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < NA; a++)
                    init[b][a] = CW'($urandom_range(0, 3));
            do_load();
            run_scan(1'($urandom_range(0, 1)), 2, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
